// File: rtl/axis_video_rx.sv
// -----------------------------------------------------------------------------
// axis_video_rx
//
// AXI-Stream video receiver at the ingress of the 3DNR core. It waits for a
// start-of-frame beat (tuser[0]), tags each accepted pixel with its x/y raster
// position, and presents it on a single registered valid/ready output stage.
// Line-length and SOF framing errors are flagged with one-cycle pulses.
//
// Parameters
//   DW   : pixel data width
//   UW   : tuser width (only bit 0 = SOF is used)
//   HRES : active pixels per line
//   VRES : active lines per frame
//   XW   : x coordinate width (2^XW > HRES)
//   YW   : y coordinate width (2^YW > VRES)
//
// Ports
//   clk, rstn                  : clock, synchronous active-low reset
//   s_axis_t{data,user,last}   : input beat, SOF on tuser[0], EOL on tlast
//   s_axis_tvalid / tready     : input handshake
//   pix_data, pix_x, pix_y     : registered pixel and its coordinates
//   pix_sof, pix_eol           : first pixel of frame / last pixel of line
//   pix_valid / pix_ready      : output handshake
//   frame_done                 : pulse after the last pixel of a frame
//   err_sof                    : pulse on an unexpected SOF
//   err_early_eol              : pulse on tlast before x = HRES-1
//   err_late_eol               : pulse on missing tlast at x = HRES-1
//   frame_cnt                  : completed frames, wraps
// -----------------------------------------------------------------------------
module axis_video_rx #(
    parameter int DW   = 24,
    parameter int UW   = 1,
    parameter int HRES = 1920,
    parameter int VRES = 1080,
    parameter int XW   = 12,
    parameter int YW   = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic [UW-1:0] s_axis_tuser,
    input  logic          s_axis_tlast,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic [DW-1:0] pix_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          frame_done,
    output logic          err_sof,
    output logic          err_early_eol,
    output logic          err_late_eol,
    output logic [15:0]   frame_cnt
);

    typedef enum logic [1:0] {
        WAIT_SOF  = 2'd0,
        ACTIVE    = 2'd1,
        DRAIN_EOL = 2'd2
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(HRES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VRES - 1);

    state_t          state_reg, state_next;
    // x_reg/y_reg hold the coordinate the next accepted beat will receive
    logic [XW-1:0]   x_reg, x_next;
    logic [YW-1:0]   y_reg, y_next;

    logic [DW-1:0]   pix_data_reg;
    logic [XW-1:0]   pix_x_reg;
    logic [YW-1:0]   pix_y_reg;
    logic            pix_sof_reg, pix_eol_reg, pix_valid_reg;
    logic            frame_done_reg, err_sof_reg, err_early_reg, err_late_reg;
    logic [15:0]     frame_cnt_reg;

    logic            accept;
    logic            sof_in;
    logic            load_beat;     // beat is written to the output stage
    logic [XW-1:0]   cur_x;         // coordinate assigned to this beat
    logic [YW-1:0]   cur_y;
    logic            eol_out;
    logic            sof_err, early_err, late_err;
    logic            line_end, frame_end;

    // Single output register stage: a new beat may enter whenever the stage
    // is empty or being emptied this cycle.
    assign s_axis_tready = rstn & (~pix_valid_reg | pix_ready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign sof_in        = s_axis_tuser[0];

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        cur_x      = x_reg;
        cur_y      = y_reg;
        load_beat  = 1'b0;
        eol_out    = 1'b0;
        sof_err    = 1'b0;
        early_err  = 1'b0;
        late_err   = 1'b0;
        line_end   = 1'b0;
        frame_end  = 1'b0;

        if (accept) begin
            case (state_reg)
                WAIT_SOF: begin
                    // Non-SOF beats are silently consumed until sync
                    if (sof_in) begin
                        load_beat = 1'b1;
                        cur_x     = '0;
                        cur_y     = '0;
                    end
                end
                ACTIVE: begin
                    load_beat = 1'b1;
                    if (sof_in && (x_reg != '0 || y_reg != '0)) begin
                        sof_err = 1'b1;
                        cur_x   = '0;
                        cur_y   = '0;
                    end
                end
                DRAIN_EOL: begin
                    if (sof_in) begin
                        // A new frame starts inside the overlong line
                        load_beat = 1'b1;
                        sof_err   = 1'b1;
                        cur_x     = '0;
                        cur_y     = '0;
                    end else if (s_axis_tlast) begin
                        line_end   = 1'b1;
                        state_next = ACTIVE;
                    end
                end
                default: state_next = WAIT_SOF;
            endcase
        end

        // Line-length checks for any beat that reaches the output
        if (load_beat) begin
            state_next = ACTIVE;
            if (s_axis_tlast) begin
                eol_out   = 1'b1;
                line_end  = 1'b1;
                early_err = (cur_x != X_LAST);
            end else if (cur_x == X_LAST) begin
                // Line is full but tlast missing: drop the rest of it
                eol_out    = 1'b1;
                late_err   = 1'b1;
                x_next     = cur_x;
                y_next     = cur_y;
                state_next = DRAIN_EOL;
            end else begin
                x_next = cur_x + 1'b1;
                y_next = cur_y;
            end
        end

        if (line_end) begin
            x_next = '0;
            if (cur_y == Y_LAST) begin
                frame_end  = 1'b1;
                y_next     = '0;
                state_next = WAIT_SOF;
            end else begin
                y_next = cur_y + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= WAIT_SOF;
            x_reg          <= '0;
            y_reg          <= '0;
            pix_data_reg   <= '0;
            pix_x_reg      <= '0;
            pix_y_reg      <= '0;
            pix_sof_reg    <= 1'b0;
            pix_eol_reg    <= 1'b0;
            pix_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            err_sof_reg    <= 1'b0;
            err_early_reg  <= 1'b0;
            err_late_reg   <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            frame_done_reg <= frame_end;
            err_sof_reg    <= sof_err;
            err_early_reg  <= early_err;
            err_late_reg   <= late_err;
            if (frame_end) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            // Stage empties or refills whenever it is allowed to move
            if (s_axis_tready) begin
                pix_valid_reg <= load_beat;
            end
            if (load_beat) begin
                pix_data_reg <= s_axis_tdata;
                pix_x_reg    <= cur_x;
                pix_y_reg    <= cur_y;
                pix_sof_reg  <= sof_in;
                pix_eol_reg  <= eol_out;
            end
        end
    end

    assign pix_data      = pix_data_reg;
    assign pix_x         = pix_x_reg;
    assign pix_y         = pix_y_reg;
    assign pix_sof       = pix_sof_reg;
    assign pix_eol       = pix_eol_reg;
    assign pix_valid     = pix_valid_reg;
    assign frame_done    = frame_done_reg;
    assign err_sof       = err_sof_reg;
    assign err_early_eol = err_early_reg;
    assign err_late_eol  = err_late_reg;
    assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_axis_video_rx.sv
// -----------------------------------------------------------------------------
// tb_axis_video_rx
//
// Scoreboard bench for axis_video_rx with HRES=4, VRES=2. Each driven beat
// carries its hand-written expected output (or none if it must be dropped);
// the monitor pops and compares on every output transfer. Pulse outputs are
// counted and compared per scenario.
// -----------------------------------------------------------------------------
module tb_axis_video_rx;

    localparam int DW = 24;
    localparam int UW = 1;
    localparam int HRES = 4;
    localparam int VRES = 2;
    localparam int XW = 12;
    localparam int YW = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_sof, pix_eol, pix_valid;
    logic          pix_ready = 1'b1;
    logic          frame_done, err_sof, err_early_eol, err_late_eol;
    logic [15:0]   frame_cnt;

    axis_video_rx #(
        .DW(DW), .UW(UW), .HRES(HRES), .VRES(VRES), .XW(XW), .YW(YW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .frame_done(frame_done),
        .err_sof(err_sof), .err_early_eol(err_early_eol),
        .err_late_eol(err_late_eol), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            x;
        int            y;
        logic          sof;
        logic          eol;
    } exp_t;

    exp_t exp_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    int n_fd = 0, n_esof = 0, n_early = 0, n_late = 0;
    int s_fd, s_esof, s_early, s_late;

    int            ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    logic [DW-1:0] data_ctr = 24'h100;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = 1'b0;
        endcase
    end

    // Output monitor, pulse counters and stall-stability checks
    logic          prev_stall = 1'b0;
    logic [DW-1:0] held_d;
    logic [XW-1:0] held_x;
    logic [YW-1:0] held_y;
    logic          held_sof, held_eol;

    always @(negedge clk) begin
        if (rstn) begin
            if (frame_done)    n_fd++;
            if (err_sof)       n_esof++;
            if (err_early_eol) n_early++;
            if (err_late_eol)  n_late++;
            if (prev_stall) begin
                check_eq("stall_valid", pix_valid, 1'b1);
                check_eq("stall_data", pix_data, held_d);
                check_eq("stall_xy", {pix_x, pix_y}, {held_x, held_y});
                check_eq("stall_flags", {pix_sof, pix_eol}, {held_sof, held_eol});
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", pix_data, 24'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] out d=%06h (%0d,%0d) sof=%0b eol=%0b", pix_data,
                             pix_x, pix_y, pix_sof, pix_eol);
                    check_eq("pix_data", pix_data, e.d);
                    check_eq("pix_x", pix_x, e.x);
                    check_eq("pix_y", pix_y, e.y);
                    check_eq("pix_sof", pix_sof, e.sof);
                    check_eq("pix_eol", pix_eol, e.eol);
                end
            end
            prev_stall = pix_valid && !pix_ready;
            held_d = pix_data; held_x = pix_x; held_y = pix_y;
            held_sof = pix_sof; held_eol = pix_eol;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Drive one beat and hold it until accepted; optionally push the output
    // it must produce.
    task automatic send(input logic sof, input logic last, input logic out,
                        input int ex, input int ey, input logic eeol);
        logic acc;
        int   n;
        exp_t e;
        data_ctr = data_ctr + 24'h1;
        if (out) begin
            e.d = data_ctr; e.x = ex; e.y = ey; e.sof = sof; e.eol = eeol;
            exp_q.push_back(e);
        end
        s_axis_tdata  = data_ctr;
        s_axis_tuser  = sof;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_eq("accept_timeout", 0, 1);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_line(input int y, input logic first_sof);
        for (int i = 0; i < HRES; i++) begin
            send(first_sof && i == 0, i == HRES - 1, 1'b1, i, y, i == HRES - 1);
        end
    endtask

    task automatic send_frame();
        for (int y = 0; y < VRES; y++) send_line(y, y == 0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pix_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) check_eq("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic begin_scen();
        s_fd = n_fd; s_esof = n_esof; s_early = n_early; s_late = n_late;
    endtask

    task automatic end_scen(input string tag, input int fc, input int fd,
                            input int esof, input int early, input int late);
        wait_drain();
        check_eq({tag, "_frame_cnt"}, frame_cnt, fc);
        check_eq({tag, "_frame_done"}, n_fd - s_fd, fd);
        check_eq({tag, "_err_sof"}, n_esof - s_esof, esof);
        check_eq({tag, "_err_early"}, n_early - s_early, early);
        check_eq({tag, "_err_late"}, n_late - s_late, late);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tready", s_axis_tready, 1'b0);
        check_eq("rst_valid", pix_valid, 1'b0);
        check_eq("rst_data", pix_data, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_pulses", {frame_done, err_sof, err_early_eol, err_late_eol}, 4'b0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: clean frame
        begin_scen();
        send_frame();
        end_scen("clean", 1, 1, 0, 0, 0);

        // 2: junk before SOF is dropped
        begin_scen();
        for (int i = 0; i < 3; i++) send(1'b0, i == 2, 1'b0, 0, 0, 1'b0);
        send_frame();
        end_scen("junk", 2, 1, 0, 0, 0);

        // 3: early EOL on beat 2 of line 0
        begin_scen();
        send(1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
        send(1'b0, 1'b1, 1'b1, 2, 0, 1'b1);
        send_line(1, 1'b0);
        end_scen("early", 3, 1, 0, 1, 0);

        // 4: late EOL, 6-beat line 0, beats 4 and 5 dropped
        begin_scen();
        for (int i = 0; i < 6; i++) begin
            send(i == 0, i == 5, i < 4, i, 0, i == 3);
        end
        send_line(1, 1'b0);
        end_scen("late", 4, 1, 0, 0, 1);

        // 5: SOF on beat 5 resyncs the frame
        begin_scen();
        send_line(0, 1'b1);
        send(1'b0, 1'b0, 1'b1, 0, 1, 1'b0);
        send(1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        for (int i = 1; i < HRES; i++) send(1'b0, i == HRES - 1, 1'b1, i, 0, i == HRES - 1);
        wait_drain();
        check_eq("midsof_cnt_hold", frame_cnt, 4);
        send_line(1, 1'b0);
        end_scen("midsof", 5, 1, 1, 0, 0);

        // 6a: random backpressure over two frames
        begin_scen();
        ready_mode = 1;
        send_frame();
        send_frame();
        end_scen("bp", 7, 2, 0, 0, 0);

        // 6b: reset mid-line with a stalled output
        ready_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        send(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        check_eq("stalled_valid", pix_valid, 1'b1);
        check_eq("stalled_tready", s_axis_tready, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_valid", pix_valid, 1'b0);
        check_eq("mid_rst_data", pix_data, 0);
        check_eq("mid_rst_xy", {pix_x, pix_y}, 0);
        check_eq("mid_rst_flags", {pix_sof, pix_eol}, 2'b0);
        check_eq("mid_rst_frame_cnt", frame_cnt, 0);
        check_eq("mid_rst_tready", s_axis_tready, 1'b0);
        ready_mode = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        begin_scen();
        send(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        send_frame();
        end_scen("post_rst", 1, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
